// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, bus-owner encoding,
// and small helpers that classify states by the strobes they assert.
package sram_arbiter_pkg;

    localparam int SRAM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    // Chip is selected for the whole access, including write setup and hold.
    function automatic logic chip_selected(input state_e s);
        return (s == ST_RD) || (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
    endfunction

    // Data bus is driven from setup through hold so data brackets the we_n pulse.
    function automatic logic drives_bus(input state_e s);
        return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one asynchronous external SRAM between the instruction-fetch port
//   (IF) and the data port (MEM). MEM has fixed priority; one access is in
//   flight at a time and every access returns to IDLE before the next grant,
//   which gives the bus a turnaround cycle. Completion is a one-cycle ready
//   pulse to the owner.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           IF read request (level) and byte address
//   if_rdata/if_ready        IF read data (held) and completion pulse
//   mem_req/mem_we/mem_addr  MEM request (level), write flag, byte address
//   mem_wdata                MEM write data
//   mem_rdata/mem_ready      MEM read data (held) and completion pulse
//   ram_addr                 SRAM word address (byte address bits [ADDR_WIDTH+1:2])
//   ram_dout/ram_dout_en     write data and its tristate enable
//   ram_din                  read data from the SRAM bus
//   ram_ce_n/oe_n/we_n       active-low SRAM strobes
//
// Every output is a flop, so no request input reaches a pin combinationally.
// Strobe flops are loaded from the *next* state, so the pins always reflect
// the state the FSM is currently in. WAIT_CYCLES must be at least 1.

import sram_arbiter_pkg::*;

module sram_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_ready,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_dout,
    output logic                  ram_dout_en,
    input  logic [31:0]           ram_din,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    localparam int                CNT_W    = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]             ram_dout_q, ram_dout_d;
    logic                    ram_dout_en_q, ram_dout_en_d;
    logic                    ram_ce_n_q, ram_ce_n_d;
    logic                    ram_oe_n_q, ram_oe_n_d;
    logic                    ram_we_n_q, ram_we_n_d;
    logic [31:0]             if_rdata_q, if_rdata_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic                    if_ready_q, if_ready_d;
    logic                    mem_ready_q, mem_ready_d;

    // Byte-lane and above-range address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_WIDTH+2],
                                mem_addr[1:0], mem_addr[31:ADDR_WIDTH+2]};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    owner_d    = OWNER_MEM;
                    ram_addr_d = mem_addr[ADDR_WIDTH+1:2];
                    cnt_d      = '0;
                    if (mem_we) begin
                        ram_dout_d = mem_wdata;
                        state_d    = ST_WR_SETUP;
                    end else begin
                        state_d    = ST_RD;
                    end
                end else if (if_req) begin
                    owner_d    = OWNER_IF;
                    ram_addr_d = if_addr[ADDR_WIDTH+1:2];
                    cnt_d      = '0;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                // Data is captured at the edge that ends the last oe_n-low cycle.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_d = ram_din;
                    end else begin
                        if_rdata_d = ram_din;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_SETUP: begin
                cnt_d   = '0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ram_ce_n_d    = !chip_selected(state_d);
        ram_oe_n_d    = (state_d != ST_RD);
        ram_we_n_d    = (state_d != ST_WR_PULSE);
        ram_dout_en_d = drives_bus(state_d);
        if_ready_d    = (state_d == ST_DONE) && (owner_d == OWNER_IF);
        mem_ready_d   = (state_d == ST_DONE) && (owner_d == OWNER_MEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_IF;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_dout_q    <= '0;
            ram_dout_en_q <= 1'b0;
            ram_ce_n_q    <= 1'b1;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            if_rdata_q    <= '0;
            mem_rdata_q   <= '0;
            if_ready_q    <= 1'b0;
            mem_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_dout_q    <= ram_dout_d;
            ram_dout_en_q <= ram_dout_en_d;
            ram_ce_n_q    <= ram_ce_n_d;
            ram_oe_n_q    <= ram_oe_n_d;
            ram_we_n_q    <= ram_we_n_d;
            if_rdata_q    <= if_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
            if_ready_q    <= if_ready_d;
            mem_ready_q   <= mem_ready_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_dout    = ram_dout_q;
    assign ram_dout_en = ram_dout_en_q;
    assign ram_ce_n    = ram_ce_n_q;
    assign ram_oe_n    = ram_oe_n_q;
    assign ram_we_n    = ram_we_n_q;
    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ready   = mem_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (WAIT_CYCLES=1 and 3), each attached
// to a behavioural SRAM. Expected latencies, strobe widths and read data come
// from the access rules and a word-array model of memory contents.
module tb_sram_arbiter;

    localparam int AW = 8;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        int          n_oe;
        int          n_we;
        int          n_den;
        int          n_oth;
        logic [AW-1:0] addr_seen;
        logic [31:0] dout_seen;
    } res_t;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    logic          clk;
    logic          rst       [2];
    logic          if_req    [2];
    logic [31:0]   if_addr   [2];
    logic [31:0]   if_rdata  [2];
    logic          if_ready  [2];
    logic          mem_req   [2];
    logic          mem_we    [2];
    logic [31:0]   mem_addr  [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];
    logic          mem_ready [2];
    logic [AW-1:0] ram_addr  [2];
    logic [31:0]   ram_dout  [2];
    logic          ram_dout_en [2];
    logic [31:0]   ram_din   [2];
    logic          ram_ce_n  [2];
    logic          ram_oe_n  [2];
    logic          ram_we_n  [2];

    logic          din_force [2];
    logic [31:0]   din_val   [2];
    logic [31:0]   sram      [2][256];
    logic [31:0]   model_mem [2][256];

    int n_oe [2], n_we [2], n_den [2], n_ifr [2], n_memr [2];
    logic [AW-1:0] addr_seen [2];
    logic [31:0]   dout_seen [2];

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
        .ram_addr(ram_addr[0]), .ram_dout(ram_dout[0]), .ram_dout_en(ram_dout_en[0]), .ram_din(ram_din[0]),
        .ram_ce_n(ram_ce_n[0]), .ram_oe_n(ram_oe_n[0]), .ram_we_n(ram_we_n[0])
    );

    sram_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
        .ram_addr(ram_addr[1]), .ram_dout(ram_dout[1]), .ram_dout_en(ram_dout_en[1]), .ram_din(ram_din[1]),
        .ram_ce_n(ram_ce_n[1]), .ram_oe_n(ram_oe_n[1]), .ram_we_n(ram_we_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: write while ce_n and we_n low; read data only while oe_n low.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ram_din[k] = 32'h0;
            if (din_force[k]) ram_din[k] = din_val[k];
            else if (!ram_oe_n[k]) ram_din[k] = sram[k][ram_addr[k]];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (!ram_ce_n[k] && !ram_we_n[k]) sram[k][ram_addr[k]] <= ram_dout[k];
    end

    // Cumulative strobe/pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            n_oe[k]   <= n_oe[k]   + (ram_oe_n[k] ? 0 : 1);
            n_we[k]   <= n_we[k]   + (ram_we_n[k] ? 0 : 1);
            n_den[k]  <= n_den[k]  + (ram_dout_en[k] ? 1 : 0);
            n_ifr[k]  <= n_ifr[k]  + (if_ready[k] ? 1 : 0);
            n_memr[k] <= n_memr[k] + (mem_ready[k] ? 1 : 0);
            if (!ram_ce_n[k]) addr_seen[k] <= ram_addr[k];
            if (!ram_we_n[k]) dout_seen[k] <= ram_dout[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input int k, input bit is_mem, input bit we,
                          input logic [31:0] a, input logic [31:0] wd, output res_t r);
        int b_oe, b_we, b_den, b_oth;
        @(negedge clk);
        if (is_mem) begin
            mem_req[k] = 1'b1; mem_we[k] = we; mem_addr[k] = a; mem_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = a;
        end
        #1;
        b_oe = n_oe[k]; b_we = n_we[k]; b_den = n_den[k];
        b_oth = is_mem ? n_ifr[k] : n_memr[k];
        r.lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (is_mem ? mem_ready[k] : if_ready[k]) begin
                r.lat = c;
                break;
            end
        end
        mem_req[k] = 1'b0; mem_we[k] = 1'b0; if_req[k] = 1'b0;
        r.rd = is_mem ? mem_rdata[k] : if_rdata[k];
        #1;
        r.n_oe  = n_oe[k] - b_oe;
        r.n_we  = n_we[k] - b_we;
        r.n_den = n_den[k] - b_den;
        r.n_oth = (is_mem ? n_ifr[k] : n_memr[k]) - b_oth;
        r.addr_seen = addr_seen[k];
        r.dout_seen = dout_seen[k];
    endtask

    task automatic check_access(input int k, input bit is_mem, input bit we,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input string tag);
        res_t r;
        int   w;
        bit   wr;
        w  = wait_of(k);
        wr = is_mem && we;
        access(k, is_mem, we, a, wd, r);
        chk({tag, " latency"}, 64'(r.lat), 64'(wr ? w + 3 : w + 1));
        chk({tag, " oe_n low cycles"}, 64'(r.n_oe), 64'(wr ? 0 : w));
        chk({tag, " we_n low cycles"}, 64'(r.n_we), 64'(wr ? w : 0));
        chk({tag, " dout_en cycles"}, 64'(r.n_den), 64'(wr ? w + 2 : 0));
        chk({tag, " other ready"}, 64'(r.n_oth), 64'(0));
        chk({tag, " ram_addr"}, 64'(r.addr_seen), 64'(a[AW+1:2]));
        if (wr) begin
            chk({tag, " ram_dout"}, 64'(r.dout_seen), 64'(wd));
            model_mem[k][a[AW+1:2]] = wd;
        end else begin
            chk({tag, " rdata"}, 64'(r.rd), 64'(exp_rd));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int          c_mem, c_if, nrdy;
        int          rdy_c[2];
        int          b_ifr, b_oe;
        logic [31:0] a, wd, exp_rd;
        bit          is_mem, we;
        int          idx;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
            mem_req[k] = 1'b0; mem_we[k] = 1'b0; mem_addr[k] = '0; mem_wdata[k] = '0;
            din_force[k] = 1'b0; din_val[k] = '0;
            n_oe[k] = 0; n_we[k] = 0; n_den[k] = 0; n_ifr[k] = 0; n_memr[k] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int k = 0; k < 2; k++) begin
            chk("reset strobes", 64'({ram_ce_n[k], ram_oe_n[k], ram_we_n[k], ram_dout_en[k],
                                      if_ready[k], mem_ready[k]}), 64'(6'b111000));
            chk("reset data", 64'({if_rdata[k], mem_rdata[k]}), 64'(0));
            chk("reset bus", 64'({ram_addr[k], ram_dout[k]}), 64'(0));
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Prefill the first 16 words through MEM writes
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                check_access(k, 1'b1, 1'b1, i << 2, 32'h5A00_0000 + (i * 32'h0101) + k, 32'h0, "prefill");

        vecs[0] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_000B, 32'h0,         32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_5A5A};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0009, 32'h0,         32'h0000_0000};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_03FE, 32'h0,         32'hA5A5_5A5A};
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 8; v++)
                check_access(k, vecs[v].is_mem, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                             vecs[v].exp_rd, "vector");

        // IF read of 0x10 with a fixed bus value, single wait cycle
        din_force[0] = 1'b1; din_val[0] = 32'hDEAD_BEEF;
        check_access(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "if_read_w1");
        din_force[0] = 1'b0;

        // Three wait cycles: only the value on the last oe_n-low cycle is captured
        @(negedge clk);
        din_force[1] = 1'b1; din_val[1] = 32'h1111_1111;
        if_req[1] = 1'b1; if_addr[1] = 32'h0000_0014;
        #1; b_oe = n_oe[1];
        c_if = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (if_ready[1]) begin c_if = c; break; end
            din_val[1] = (c == 3) ? 32'hCAFE_F00D : 32'h1111_1111 * (c + 1);
        end
        if_req[1] = 1'b0;
        chk("w3 ready cycle", 64'(c_if), 64'(4));
        chk("w3 if_rdata", 64'(if_rdata[1]), 64'(32'hCAFE_F00D));
        #1;
        chk("w3 oe_n low cycles", 64'(n_oe[1] - b_oe), 64'(3));
        din_force[1] = 1'b0;

        // Simultaneous requests: MEM first, IF after the separating IDLE
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0024;
        mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h0000_0020;
        c_mem = -1; c_if = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (mem_ready[0] && if_ready[0]) chk("both ready together", 64'(1), 64'(0));
            if (mem_ready[0]) begin
                c_mem = c; mem_req[0] = 1'b0;
                chk("arb mem_rdata", 64'(mem_rdata[0]), 64'(model_mem[0][8]));
            end
            if (if_ready[0]) begin
                c_if = c; if_req[0] = 1'b0;
                chk("arb if_rdata", 64'(if_rdata[0]), 64'(model_mem[0][9]));
                break;
            end
        end
        mem_req[0] = 1'b0; if_req[0] = 1'b0;
        chk("arb mem ready cycle", 64'(c_mem), 64'(2));
        chk("arb if ready cycle", 64'(c_if), 64'(5));

        // IF request held across two accesses
        @(negedge clk);
        din_force[0] = 1'b1; din_val[0] = 32'h0A0A_0A0A;
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0010;
        #1; b_ifr = n_ifr[0];
        nrdy = 0; rdy_c[0] = -1; rdy_c[1] = -1;
        for (int c = 1; c <= 12 && nrdy < 2; c++) begin
            @(negedge clk);
            if (c >= 2) din_val[0] = 32'h0B0B_0B0B;
            if (nrdy == 1 && !if_ready[0])
                chk("held if_rdata between pulses", 64'(if_rdata[0]), 64'(32'h0A0A_0A0A));
            if (if_ready[0]) begin
                rdy_c[nrdy] = c;
                nrdy++;
            end
        end
        if_req[0] = 1'b0;
        chk("hold first ready cycle", 64'(rdy_c[0]), 64'(2));
        chk("hold second ready cycle", 64'(rdy_c[1]), 64'(5));
        chk("hold second if_rdata", 64'(if_rdata[0]), 64'(32'h0B0B_0B0B));
        #1;
        chk("hold pulse count", 64'(n_ifr[0] - b_ifr), 64'(2));
        din_force[0] = 1'b0;

        // Reset asserted in the middle of a read
        @(negedge clk);
        if_req[1] = 1'b1; if_addr[1] = 32'h0000_0040;
        @(negedge clk);
        chk("pre-reset oe_n", 64'(ram_oe_n[1]), 64'(0));
        rst[1] = 1'b1; if_req[1] = 1'b0;
        #1; b_ifr = n_ifr[1];
        @(negedge clk);
        chk("mid-rd reset strobes", 64'({ram_ce_n[1], ram_oe_n[1], ram_we_n[1], ram_dout_en[1]}),
            64'(4'b1110));
        chk("mid-rd reset if_rdata", 64'(if_rdata[1]), 64'(0));
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid-rd reset no ready", 64'(n_ifr[1] - b_ifr), 64'(0));
        check_access(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, model_mem[1][1], "post_reset");

        // Randomized traffic against the word-array model
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 30; n++) begin
                idx    = $urandom_range(0, 15);
                is_mem = 1'($urandom_range(0, 1));
                we     = is_mem && ($urandom_range(0, 1) == 1);
                a      = ($urandom() & 32'hFFFF_FC03) | (32'(idx) << 2);
                wd     = $urandom();
                exp_rd = model_mem[k][idx];
                check_access(k, is_mem, we, a, wd, exp_rd, "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
